// File: rtl/mchan_trans_splitter_ipa_if.sv
// Command handshake bundle shared by the upstream command port and the downstream
// sub-command port of the transfer splitter. The upstream port leaves last unused.
interface mchan_trans_splitter_ipa_if #(
  parameter int unsigned MCHAN_LEN_WIDTH = 17,
  parameter int unsigned TCDM_ADD_WIDTH  = 16,
  parameter int unsigned EXT_ADD_WIDTH   = 32,
  parameter int unsigned MCHAN_OPC_WIDTH = 1,
  parameter int unsigned TRANS_SID_WIDTH = 1,
  parameter int unsigned TRANS_CID_WIDTH = 1
);

  logic                       req;
  logic                       gnt;
  logic [EXT_ADD_WIDTH-1:0]   ext_add;
  logic [TCDM_ADD_WIDTH-1:0]  tcdm_add;
  logic [MCHAN_LEN_WIDTH-1:0] len;
  logic [MCHAN_OPC_WIDTH-1:0] opc;
  logic [TRANS_SID_WIDTH-1:0] sid;
  logic [TRANS_CID_WIDTH-1:0] cid;
  logic                       last;

  modport master (
    output req, ext_add, tcdm_add, len, opc, sid, cid, last,
    input  gnt
  );

  modport slave (
    input  req, ext_add, tcdm_add, len, opc, sid, cid, last,
    output gnt
  );

endinterface

// File: rtl/mchan_trans_splitter_ipa.sv
// Splits one 1D transfer command into sub-commands that never cross a
// 2^BOUNDARY_WIDTH-byte window of the external address.
module mchan_trans_splitter_ipa #(
  parameter int unsigned MCHAN_LEN_WIDTH = 17,
  parameter int unsigned BOUNDARY_WIDTH  = 7,
  parameter int unsigned TCDM_ADD_WIDTH  = 16,
  parameter int unsigned EXT_ADD_WIDTH   = 32,
  parameter int unsigned MCHAN_OPC_WIDTH = 1,
  parameter int unsigned TRANS_SID_WIDTH = 1,
  parameter int unsigned TRANS_CID_WIDTH = 1
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  mchan_trans_splitter_ipa_if.slave    cmd,
  mchan_trans_splitter_ipa_if.master   sub
);

  localparam int unsigned LW = MCHAN_LEN_WIDTH;
  localparam int unsigned BW = BOUNDARY_WIDTH;
  localparam logic [BW:0] Window = {1'b1, {BW{1'b0}}};

  typedef enum logic {StIdle, StSplit} state_e;

  state_e                     state_q;
  logic                       req_q;
  logic                       gnt_q;
  logic [EXT_ADD_WIDTH-1:0]   cur_ext_q;
  logic [TCDM_ADD_WIDTH-1:0]  cur_tcdm_q;
  logic [LW-1:0]              rem_q;
  logic [MCHAN_OPC_WIDTH-1:0] opc_q;
  logic [TRANS_SID_WIDTH-1:0] sid_q;
  logic [TRANS_CID_WIDTH-1:0] cid_q;

  logic [BW-1:0] off;
  logic [BW:0]   space;
  logic [LW:0]   space_w;
  logic [LW-1:0] space_m1;
  logic          last;
  logic [LW-1:0] sub_len;

  // Bytes left in the current window; compared at LW+1 bits so a full window
  // still fits when BOUNDARY_WIDTH equals the length width.
  always_comb begin
    off              = cur_ext_q[BW-1:0];
    space            = Window - {1'b0, off};
    space_w          = '0;
    space_w[BW:0]    = space;
    space_m1         = '0;
    space_m1[BW-1:0] = ~off;
    last             = {1'b0, rem_q} < space_w;
    sub_len          = last ? rem_q : space_m1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      gnt_q      <= 1'b1;
      cur_ext_q  <= '0;
      cur_tcdm_q <= '0;
      rem_q      <= '0;
      opc_q      <= '0;
      sid_q      <= '0;
      cid_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd.req) begin
            cur_ext_q  <= cmd.ext_add;
            cur_tcdm_q <= cmd.tcdm_add;
            rem_q      <= cmd.len;
            opc_q      <= cmd.opc;
            sid_q      <= cmd.sid;
            cid_q      <= cmd.cid;
            state_q    <= StSplit;
            req_q      <= 1'b1;
            gnt_q      <= 1'b0;
          end
        end
        StSplit: begin
          if (sub.gnt) begin
            if (last) begin
              state_q <= StIdle;
              req_q   <= 1'b0;
              gnt_q   <= 1'b1;
            end else begin
              cur_ext_q  <= cur_ext_q + EXT_ADD_WIDTH'(space);
              cur_tcdm_q <= cur_tcdm_q + TCDM_ADD_WIDTH'(space);
              rem_q      <= rem_q - space_w[LW-1:0];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd.gnt      = gnt_q;
  assign sub.req      = req_q;
  assign sub.ext_add  = cur_ext_q;
  assign sub.tcdm_add = cur_tcdm_q;
  assign sub.len      = sub_len;
  assign sub.last     = req_q & last;
  assign sub.opc      = opc_q;
  assign sub.sid      = sid_q;
  assign sub.cid      = cid_q;

endmodule

// File: tb/tb_mchan_trans_splitter_ipa.sv
// Randomised bench for the transfer splitter: every sub-command is compared against
// a byte-count reference model of the 128 B window split.
module tb_mchan_trans_splitter_ipa;

  localparam int unsigned Win = 128;

  typedef struct {
    logic [31:0] ext;
    logic [15:0] tcdm;
    logic [16:0] len;
    logic        last;
  } sub_t;

  logic clk;
  logic rst_ni;
  int   n_checks;
  int   n_fail;
  sub_t exp_q[$];

  mchan_trans_splitter_ipa_if #(
    .MCHAN_LEN_WIDTH(17), .TCDM_ADD_WIDTH(16), .EXT_ADD_WIDTH(32),
    .MCHAN_OPC_WIDTH(1), .TRANS_SID_WIDTH(1), .TRANS_CID_WIDTH(1)
  ) cmd_if ();

  mchan_trans_splitter_ipa_if #(
    .MCHAN_LEN_WIDTH(17), .TCDM_ADD_WIDTH(16), .EXT_ADD_WIDTH(32),
    .MCHAN_OPC_WIDTH(1), .TRANS_SID_WIDTH(1), .TRANS_CID_WIDTH(1)
  ) sub_if ();

  mchan_trans_splitter_ipa #(
    .MCHAN_LEN_WIDTH(17), .BOUNDARY_WIDTH(7), .TCDM_ADD_WIDTH(16), .EXT_ADD_WIDTH(32),
    .MCHAN_OPC_WIDTH(1), .TRANS_SID_WIDTH(1), .TRANS_CID_WIDTH(1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .cmd    (cmd_if),
    .sub    (sub_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: walk the byte range, cutting each piece at the next window edge.
  function automatic void build_expected(input logic [31:0] ext, input logic [15:0] tcdm,
                                         input logic [16:0] len);
    int unsigned left;
    int unsigned room;
    int unsigned take;
    logic [31:0] e;
    logic [15:0] t;
    sub_t        s;
    exp_q.delete();
    left = int'(len) + 1;
    e    = ext;
    t    = tcdm;
    while (left > 0) begin
      room   = Win - (e % Win);
      take   = (left < room) ? left : room;
      s.ext  = e;
      s.tcdm = t;
      s.len  = 17'(take - 1);
      s.last = (take == left);
      exp_q.push_back(s);
      e    = e + 32'(take);
      t    = t + 16'(take);
      left = left - take;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the final grant.
  task automatic run_cmd(input logic [31:0] ext, input logic [15:0] tcdm, input logic [16:0] len,
                         input logic opc, input logic sid, input logic cid,
                         input int unsigned gnt_pct, input int unsigned stall);
    int unsigned n;
    int unsigned idx;
    int unsigned cyc;
    int unsigned budget;
    int unsigned exp_cnt;
    logic        g;
    build_expected(ext, tcdm, len);
    n       = exp_q.size();
    exp_cnt = ((ext % Win) + int'(len) + 1 + Win - 1) / Win;
    budget  = 8 * n + 40;
    check_eq("idle_gnt_o", 64'(cmd_if.gnt), 64'd1);
    check_eq("idle_req_o", 64'(sub_if.req), 64'd0);
    cmd_if.req      = 1'b1;
    cmd_if.ext_add  = ext;
    cmd_if.tcdm_add = tcdm;
    cmd_if.len      = len;
    cmd_if.opc      = opc;
    cmd_if.sid      = sid;
    cmd_if.cid      = cid;
    sub_if.gnt      = 1'($urandom_range(1));
    @(negedge clk);
    cmd_if.req      = 1'b0;
    cmd_if.ext_add  = $urandom;
    cmd_if.tcdm_add = 16'($urandom);
    cmd_if.len      = 17'($urandom);
    cmd_if.opc      = ~opc;
    cmd_if.sid      = ~sid;
    cmd_if.cid      = ~cid;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < budget) begin
      check_eq("req_o", 64'(sub_if.req), 64'd1);
      check_eq("busy_gnt_o", 64'(cmd_if.gnt), 64'd0);
      check_eq("ext_add_o", 64'(sub_if.ext_add), 64'(exp_q[idx].ext));
      check_eq("tcdm_add_o", 64'(sub_if.tcdm_add), 64'(exp_q[idx].tcdm));
      check_eq("len_o", 64'(sub_if.len), 64'(exp_q[idx].len));
      check_eq("last_o", 64'(sub_if.last), 64'(exp_q[idx].last));
      check_eq("opc_o", 64'(sub_if.opc), 64'(opc));
      check_eq("sid_o", 64'(sub_if.sid), 64'(sid));
      check_eq("cid_o", 64'(sub_if.cid), 64'(cid));
      if (stall > 0) begin
        g = 1'b0;
        stall--;
      end else begin
        g = ($urandom_range(99) < gnt_pct);
      end
      sub_if.gnt = g;
      @(negedge clk);
      if (g) idx++;
      cyc++;
    end
    check_eq("sub_count", 64'(idx), 64'(exp_cnt));
    check_eq("bubble_gnt_o", 64'(cmd_if.gnt), 64'd1);
    check_eq("bubble_req_o", 64'(sub_if.req), 64'd0);
    check_eq("bubble_last_o", 64'(sub_if.last), 64'd0);
    sub_if.gnt = 1'($urandom_range(1));
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_ni          = 1'b0;
    cmd_if.req      = 1'b0;
    cmd_if.ext_add  = '0;
    cmd_if.tcdm_add = '0;
    cmd_if.len      = '0;
    cmd_if.opc      = '0;
    cmd_if.sid      = '0;
    cmd_if.cid      = '0;
    cmd_if.last     = 1'b0;
    sub_if.gnt      = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_gnt_o", 64'(cmd_if.gnt), 64'd1);
    check_eq("rst_req_o", 64'(sub_if.req), 64'd0);
    check_eq("rst_last_o", 64'(sub_if.last), 64'd0);
    check_eq("rst_ext_add_o", 64'(sub_if.ext_add), 64'd0);
    check_eq("rst_tcdm_add_o", 64'(sub_if.tcdm_add), 64'd0);
    check_eq("rst_opc_sid_cid", 64'({sub_if.opc, sub_if.sid, sub_if.cid}), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Directed scenarios: single window, crossing, aligned 3-window, stall, wrap.
    run_cmd(32'h1000_0000, 16'h0040, 17'h0003F, 1'b1, 1'b1, 1'b1, 100, 0);
    run_cmd(32'h1000_0070, 16'h0100, 17'h0001F, 1'b0, 1'b1, 1'b0, 100, 0);
    run_cmd(32'h2000_0000, 16'h0000, 17'h0017F, 1'b1, 1'b0, 1'b1, 100, 0);
    run_cmd(32'h1000_0070, 16'h0100, 17'h0001F, 1'b0, 1'b0, 1'b1, 100, 5);
    run_cmd(32'hFFFF_FFF8, 16'hFFFC, 17'h0000F, 1'b1, 1'b1, 1'b0, 100, 0);

    // Abort mid-split: reset right after the first grant of a 3-window command.
    cmd_if.req      = 1'b1;
    cmd_if.ext_add  = 32'h2000_0000;
    cmd_if.tcdm_add = 16'h0000;
    cmd_if.len      = 17'h0017F;
    @(negedge clk);
    cmd_if.req = 1'b0;
    check_eq("abort_first_req_o", 64'(sub_if.req), 64'd1);
    sub_if.gnt = 1'b1;
    @(negedge clk);
    check_eq("abort_second_ext", 64'(sub_if.ext_add), 64'h2000_0080);
    rst_ni = 1'b0;
    #1;
    check_eq("abort_async_req_o", 64'(sub_if.req), 64'd0);
    check_eq("abort_async_gnt_o", 64'(cmd_if.gnt), 64'd1);
    sub_if.gnt = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check_eq("abort_release_gnt_o", 64'(cmd_if.gnt), 64'd1);
    check_eq("abort_release_req_o", 64'(sub_if.req), 64'd0);
    run_cmd(32'h0000_0000, 16'h0000, 17'h00000, 1'b0, 1'b0, 1'b0, 100, 0);

    // Maximum length from an unaligned start, then randomised traffic.
    run_cmd(32'h0000_0123, 16'h0abc, 17'h1FFFF, 1'b1, 1'b0, 1'b0, 100, 0);
    for (int i = 0; i < 40; i++) begin
      logic [16:0] l;
      l = (i % 8 == 7) ? 17'($urandom_range(0, 17'h1FFFF)) : 17'($urandom_range(0, 600));
      run_cmd($urandom, 16'($urandom), l, 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(30, 100), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
